// File: rtl/bus_req_arbiter_pkg.sv
// Shared memory-request types for the L1-to-bus path.
// Also holds the arbiter queue entry and the arbiter FSM state types.
package mem_types_pkg;

  localparam int BLOCK_ADDR_SPACE_WIDTH = 26;

  typedef enum logic [1:0] {
    BUS_RD      = 2'd0,
    BUS_RD_X    = 2'd1,
    BUS_UPGRADE = 2'd2,
    BUS_WB      = 2'd3
  } bus_req_t;

  localparam int BUS_ARB_NUM_REQ     = 4;
  localparam int BUS_ARB_Q_DEPTH     = 4;
  localparam int BUS_ARB_LOG_NUM_REQ = $clog2(BUS_ARB_NUM_REQ);
  localparam int BUS_ARB_LOG_Q_DEPTH = $clog2(BUS_ARB_Q_DEPTH);

  typedef struct packed {
    bus_req_t                          req_type;
    logic [BLOCK_ADDR_SPACE_WIDTH-1:0] block_addr;
  } bus_arb_entry_t;

  typedef enum logic [1:0] {
    BUS_ARB_IDLE,
    BUS_ARB_REQ,
    BUS_ARB_WAIT
  } bus_arb_state_t;

endpackage

// File: rtl/bus_req_arbiter_fifo.sv
// Per-requester request queue.
// The head stays visible until the arbiter pops it on completion.
module bus_req_fifo
  import mem_types_pkg::*;
#(
  parameter int Q_DEPTH = BUS_ARB_Q_DEPTH
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           push,
  input  bus_arb_entry_t wdata,
  input  logic           pop,
  output logic           full,
  output logic           empty,
  output bus_arb_entry_t head
);

  localparam int LQ = $clog2(Q_DEPTH);

  bus_arb_entry_t r_mem [Q_DEPTH];
  logic [LQ-1:0]  r_wptr;
  logic [LQ-1:0]  r_rptr;
  logic [LQ:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign full   = (r_count == (LQ+1)'(Q_DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_req_arbiter.sv
// N-requester bus request arbiter: per-requester queues,
// round-robin pick with optional writeback priority, one transaction at a time.
module bus_req_arbiter
  import mem_types_pkg::*;
#(
  parameter int NUM_REQ     = BUS_ARB_NUM_REQ,
  parameter int Q_DEPTH     = BUS_ARB_Q_DEPTH,
  parameter int MULTICORE   = 1,
  parameter int WB_PRIORITY = 1
) (
  input  logic                                           CLK,
  input  logic                                           nRST,
  input  logic [NUM_REQ-1:0]                             in_valid,
  output logic [NUM_REQ-1:0]                             in_ready,
  input  logic [NUM_REQ-1:0][1:0]                        in_type,
  input  logic [NUM_REQ-1:0][BLOCK_ADDR_SPACE_WIDTH-1:0] in_block_addr,
  output logic                                           mem_req_valid,
  input  logic                                           mem_req_ready,
  output bus_req_t                                       mem_req_type,
  output logic [BLOCK_ADDR_SPACE_WIDTH-1:0]              mem_req_block_addr,
  output logic [$clog2(NUM_REQ)-1:0]                     mem_req_src,
  input  logic                                           mem_done,
  output logic [NUM_REQ-1:0]                             done_valid
);

  localparam int LOG_N = $clog2(NUM_REQ);

  bus_arb_state_t r_state;
  logic [LOG_N-1:0] r_rr;
  logic [LOG_N-1:0] r_src;
  logic             r_valid;
  logic             r_skip;
  bus_req_t         r_type;
  logic [BLOCK_ADDR_SPACE_WIDTH-1:0] r_addr;
  logic [NUM_REQ-1:0] r_done;

  bus_arb_entry_t     w_head [NUM_REQ];
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_wb;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_pop;
  logic [LOG_N-1:0]   w_win;
  logic               w_any;
  logic               w_finish;
  bus_req_t           w_win_type;
  bus_req_t           w_iss_type;
  logic               w_no_mem;

  assign w_finish = (r_state == BUS_ARB_WAIT) && (mem_done || r_skip);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
    bus_arb_entry_t w_in;
    assign w_in.req_type   = bus_req_t'(in_type[i]);
    assign w_in.block_addr = in_block_addr[i];
    assign w_pop[i] = w_finish && (r_src == LOG_N'(i));
    assign w_wb[i]  = !w_empty[i] && (w_head[i].req_type == BUS_WB);
    bus_req_fifo #(.Q_DEPTH(Q_DEPTH)) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (in_valid[i]),
      .wdata (w_in),
      .pop   (w_pop[i]),
      .full  (w_full[i]),
      .empty (w_empty[i]),
      .head  (w_head[i])
    );
  end

  assign in_ready = ~w_full;
  assign w_cand   = (WB_PRIORITY != 0 && |w_wb) ? w_wb : ~w_empty;

  // First candidate at or after the RR pointer, wrapping.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand[(int'(r_rr) + k) % NUM_REQ]) begin
        w_win = LOG_N'((int'(r_rr) + k) % NUM_REQ);
        w_any = 1'b1;
      end
    end
  end

  // Unicore remaps exclusive reads and completes upgrades locally.
  always_comb begin
    w_win_type = w_head[w_win].req_type;
    w_iss_type = w_win_type;
    w_no_mem   = 1'b0;
    if (MULTICORE == 0) begin
      if (w_win_type == BUS_RD_X)    w_iss_type = BUS_RD;
      if (w_win_type == BUS_UPGRADE) w_no_mem   = 1'b1;
    end
  end

  // Arbiter FSM with registered request and completion outputs.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= BUS_ARB_IDLE;
      r_rr    <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
      r_skip  <= 1'b0;
      r_type  <= BUS_RD;
      r_addr  <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        BUS_ARB_IDLE: begin
          if (w_any) begin
            r_type <= w_iss_type;
            r_addr <= w_head[w_win].block_addr;
            r_src  <= w_win;
            if (w_no_mem) begin
              r_skip  <= 1'b1;
              r_state <= BUS_ARB_WAIT;
            end else begin
              r_valid <= 1'b1;
              r_state <= BUS_ARB_REQ;
            end
          end
        end
        BUS_ARB_REQ: begin
          if (mem_req_ready) begin
            r_valid <= 1'b0;
            r_state <= BUS_ARB_WAIT;
          end
        end
        BUS_ARB_WAIT: begin
          if (w_finish) begin
            r_done  <= NUM_REQ'(1) << r_src;
            r_skip  <= 1'b0;
            r_rr    <= (r_src == LOG_N'(NUM_REQ - 1)) ? '0 : r_src + 1'b1;
            r_state <= BUS_ARB_IDLE;
          end
        end
        default: r_state <= BUS_ARB_IDLE;
      endcase
    end
  end

  assign mem_req_valid      = r_valid;
  assign mem_req_type       = r_type;
  assign mem_req_block_addr = r_addr;
  assign mem_req_src        = r_src;
  assign done_valid         = r_done;

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed bench for bus_req_arbiter.
// Three instances share stimulus: default, no WB priority, unicore.
module tb_bus_req_arbiter;
  import mem_types_pkg::*;

  localparam int W = BLOCK_ADDR_SPACE_WIDTH;

  logic CLK = 1'b0;
  logic nRST;
  logic [3:0]        in_valid;
  logic [3:0][1:0]   in_type;
  logic [3:0][W-1:0] in_block_addr;
  logic mem_req_ready;
  logic mem_done;

  logic [3:0] rdy0, rdy1, rdy2;
  logic       mv0, mv1, mv2;
  bus_req_t   mt0, mt1, mt2;
  logic [W-1:0] ma0, ma1, ma2;
  logic [1:0] ms0, ms1, ms2;
  logic [3:0] dv0, dv1, dv2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bus_req_arbiter u0 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy0),
    .in_type(in_type), .in_block_addr(in_block_addr),
    .mem_req_valid(mv0), .mem_req_ready(mem_req_ready),
    .mem_req_type(mt0), .mem_req_block_addr(ma0), .mem_req_src(ms0),
    .mem_done(mem_done), .done_valid(dv0)
  );

  bus_req_arbiter #(.WB_PRIORITY(0)) u1 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy1),
    .in_type(in_type), .in_block_addr(in_block_addr),
    .mem_req_valid(mv1), .mem_req_ready(mem_req_ready),
    .mem_req_type(mt1), .mem_req_block_addr(ma1), .mem_req_src(ms1),
    .mem_done(mem_done), .done_valid(dv1)
  );

  bus_req_arbiter #(.MULTICORE(0)) u2 (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(rdy2),
    .in_type(in_type), .in_block_addr(in_block_addr),
    .mem_req_valid(mv2), .mem_req_ready(mem_req_ready),
    .mem_req_type(mt2), .mem_req_block_addr(ma2), .mem_req_src(ms2),
    .mem_done(mem_done), .done_valid(dv2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    in_valid = '0;
    mem_req_ready = 1'b0;
    mem_done = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  // Wait for a request on u0, check it, accept, complete 2 cycles later.
  task automatic serve(input string tag, input int src,
                       input logic [W-1:0] addr, input bus_req_t ty);
    int n = 0;
    while (mv0 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(mv0), 64'd1);
    chk({tag, "_src"}, 64'(ms0), 64'(src));
    chk({tag, "_addr"}, 64'(ma0), 64'(addr));
    chk({tag, "_type"}, 64'(mt0), 64'(ty));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk({tag, "_drop"}, 64'(mv0), 64'd0);
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk({tag, "_done"}, 64'(dv0), 64'(4'b0001 << src));
  endtask

  initial begin
    in_type = '0;
    in_block_addr = '0;

    // Reset state
    do_reset();
    chk("rst_valid", 64'(mv0), 64'd0);
    chk("rst_type", 64'(mt0), 64'd0);
    chk("rst_addr", 64'(ma0), 64'd0);
    chk("rst_src", 64'(ms0), 64'd0);
    chk("rst_done", 64'(dv0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'hF);

    // Single read from requester 1
    in_valid = 4'b0010;
    in_type[1] = BUS_RD;
    in_block_addr[1] = W'(8'h12);
    tick();
    in_valid = '0;
    chk("rd_c3_valid", 64'(mv0), 64'd0);
    tick();
    chk("rd_c4_valid", 64'(mv0), 64'd1);
    chk("rd_c4_type", 64'(mt0), 64'(BUS_RD));
    chk("rd_c4_addr", 64'(ma0), 64'h12);
    chk("rd_c4_src", 64'(ms0), 64'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rd_c5_valid", 64'(mv0), 64'd0);
    tick();
    tick();
    mem_done = 1'b1;
    chk("rd_c7_done", 64'(dv0), 64'd0);
    tick();
    mem_done = 1'b0;
    chk("rd_c8_done", 64'(dv0), 64'b0010);
    tick();
    chk("rd_c9_done", 64'(dv0), 64'd0);

    // Round robin across all four requesters
    do_reset();
    in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_type[i] = BUS_RD;
      in_block_addr[i] = W'(8'hA0 + i);
    end
    tick();
    in_valid = '0;
    serve("rr0", 0, W'(8'hA0), BUS_RD);
    serve("rr1", 1, W'(8'hA1), BUS_RD);
    tick();
    chk("rr2_busy", 64'(mv0), 64'd1);
    in_valid = 4'b0001;
    in_block_addr[0] = W'(8'hB0);
    tick();
    in_valid = '0;
    serve("rr2", 2, W'(8'hA2), BUS_RD);
    serve("rr3", 3, W'(8'hA3), BUS_RD);
    serve("rr0b", 0, W'(8'hB0), BUS_RD);

    // Writeback priority, RR pointer at 0
    do_reset();
    in_valid = 4'b0101;
    in_type[0] = BUS_RD;
    in_block_addr[0] = W'(8'h04);
    in_type[2] = BUS_WB;
    in_block_addr[2] = W'(8'h20);
    tick();
    in_valid = '0;
    tick();
    chk("nowb_src", 64'(ms1), 64'd0);
    chk("nowb_addr", 64'(ma1), 64'h04);
    serve("wb0", 2, W'(8'h20), BUS_WB);
    tick();
    chk("nowb2_src", 64'(ms1), 64'd2);
    chk("nowb2_type", 64'(mt1), 64'(BUS_WB));
    serve("wb1", 0, W'(8'h04), BUS_RD);

    // Full FIFO on requester 3 while memory stalls
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b1000;
      in_type[3] = BUS_RD;
      in_block_addr[3] = W'(8'h31 + k);
      tick();
      chk("full_rdy", 64'(rdy0[3]), (k == 3) ? 64'd0 : 64'd1);
    end
    in_block_addr[3] = W'(8'h35);
    tick();
    in_valid = '0;
    chk("full_5th_rdy", 64'(rdy0[3]), 64'd0);
    serve("f1", 3, W'(8'h31), BUS_RD);
    chk("full_rdy_back", 64'(rdy0[3]), 64'd1);
    serve("f2", 3, W'(8'h32), BUS_RD);
    serve("f3", 3, W'(8'h33), BUS_RD);
    serve("f4", 3, W'(8'h34), BUS_RD);
    for (int k = 0; k < 4; k++) tick();
    chk("full_5th_gone", 64'(mv0), 64'd0);

    // Unicore remap and local upgrade completion
    do_reset();
    in_valid = 4'b0011;
    in_type[0] = BUS_RD_X;
    in_block_addr[0] = W'(8'h08);
    in_type[1] = BUS_UPGRADE;
    in_block_addr[1] = W'(8'h09);
    tick();
    in_valid = '0;
    tick();
    chk("uni_valid", 64'(mv2), 64'd1);
    chk("uni_type", 64'(mt2), 64'(BUS_RD));
    chk("uni_addr", 64'(ma2), 64'h08);
    chk("uni_src", 64'(ms2), 64'd0);
    chk("multi_type", 64'(mt0), 64'(BUS_RD_X));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("uni_done0", 64'(dv2), 64'b0001);
    chk("uni_sel_valid", 64'(mv2), 64'd0);
    tick();
    chk("upg_valid", 64'(mv2), 64'd0);
    chk("upg_nodone", 64'(dv2), 64'd0);
    chk("multi_upg", 64'(mv0), 64'd1);
    tick();
    chk("upg_done", 64'(dv2), 64'b0010);
    chk("upg_valid2", 64'(mv2), 64'd0);
    tick();
    chk("upg_done_end", 64'(dv2), 64'd0);

    // Reset while a transaction is outstanding
    do_reset();
    in_valid = 4'b0100;
    in_type[2] = BUS_RD;
    in_block_addr[2] = W'(8'h55);
    tick();
    in_valid = '0;
    tick();
    chk("wr_valid", 64'(mv0), 64'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk("wr_rst_valid", 64'(mv0), 64'd0);
    chk("wr_rst_type", 64'(mt0), 64'd0);
    chk("wr_rst_addr", 64'(ma0), 64'd0);
    chk("wr_rst_src", 64'(ms0), 64'd0);
    chk("wr_rst_done", 64'(dv0), 64'd0);
    chk("wr_rst_ready", 64'(rdy0), 64'hF);
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("wr_late_done", 64'(dv0), 64'd0);
    tick();
    chk("wr_late_done2", 64'(dv0), 64'd0);
    chk("wr_late_valid", 64'(mv0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
